data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Responder side of the data-memory interface driven by the pipeline's memory stage.
- Accepts one load or store request at a time over a valid/ready handshake.
- Models WAIT_STATES cycles of access latency.
- Performs byte, halfword and word accesses, little-endian, with byte-lane merging on stores and sign/zero extension on loads.
- Returns a single-cycle response pulse with read data or an alignment error.
- The memory stage holds the pipeline while req_ready is low.

Parameters:
ADDR_W, 5, word-index width; memory depth is 2^ADDR_W 32-bit words
WAIT_STATES, 1, extra cycles between request acceptance and response (0..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_ready  output  1  responder can accept a request this cycle
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned access or reserved size, valid with resp_valid

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the wait counter clears.
  - req_ready=0 while reset is asserted, then 1 in IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - Memory array contents are not reset.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0.
  - RESP: req_ready=0.
- Transitions:
  - IDLE: when req_valid=1 on an edge, the request is captured (write, size, unsigned, addr, wdata) and the state moves to WAIT with counter=WAIT_STATES.
  - WAIT: while the counter is nonzero, decrement it. When it is 0, move to RESP on that edge; the memory operation happens on this same edge.
  - RESP: move to IDLE on the next edge.
- Registered outputs:
  - resp_valid is high exactly while in RESP.
  - resp_rdata and resp_err load on the edge entering RESP and hold until the next response.
- Latency: a request accepted at edge E gives resp_valid high in the cycle after edge E+WAIT_STATES+1. Throughput is one request per WAIT_STATES+3 cycles.
- Requests while busy: req_valid while req_ready=0 is ignored. The requester holds the request and all fields until it is accepted.
- Addressing:
  - Word index = addr[ADDR_W+1:2].
  - Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^(ADDR_W+2).
  - Lane = addr[1:0].
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Size 11 is always an error.
  - On error: resp_err=1, resp_rdata=0, no memory write, same latency as a normal access.
- Store:
  - Byte: writes only lane addr[1:0] with wdata[7:0].
  - Halfword: writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word: writes the full word.
  - Other bytes are preserved.
  - resp_rdata=0, resp_err=0.
- Load:
  - Selects the lane(s) and right-aligns them.
  - Bit 7 or 15 is replicated upward unless req_unsigned=1.
  - Word loads ignore req_unsigned.
- Read-after-write: a load accepted after a store's response sees the stored data.
- Reset mid-operation: state returns to IDLE. A store not yet performed (still in WAIT) is discarded. No response is issued for the aborted request.

Test Plan:
- Word path: store 0xDEADBEEF to 0x10, then load word from 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0; resp_valid 2 cycles after acceptance edge+1 (WAIT_STATES=1).
- Byte merge and sign extension: after the word store, store byte 0x80 to 0x12, then load word from 0x10 -> 0xDE80BEEF. Signed byte load from 0x12 -> 0xFFFFFF80. Unsigned byte load -> 0x00000080.
- Halfword: store half 0x8001 to 0x16, then signed half load from 0x16 -> 0xFFFF8001; unsigned half load -> 0x00008001.
- Errors:
  - Half load at 0x11 -> resp_err=1, rdata=0.
  - Word store to 0x12 -> resp_err=1, and a following word load at 0x10 shows the word unchanged.
  - Size 11 -> resp_err=1.
- Wrap and backpressure:
  - Store word 0x12345678 to 0x90 (ADDR_W=5), then load 0x10 -> 0x12345678.
  - A request held during WAIT/RESP is accepted exactly once on the edge after returning to IDLE.
- Reset mid-WAIT (WAIT_STATES=3): assert reset during WAIT of a store of 0xAAAAAAAA to 0x20 -> no resp_valid, all outputs 0. After release, a word load at 0x20 returns the prior contents.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder with fixed access latency and byte-lane merging
module data_mem_responder #(
  parameter int ADDR_W = 5,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic r_write, r_uns;
  logic [1:0] r_size;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic [1:0] lane;
  logic err, do_op;
  logic [31:0] word, sh, ld, wd, merged;
  logic [3:0] be;
  assign idx = r_addr[ADDR_W+1:2];
  assign lane = r_addr[1:0];
  assign word = mem[idx];
  assign sh = word >> {lane, 3'b000};
  assign err = r_size == 2'd3 || (r_size == 2'd1 && lane[0]) || (r_size == 2'd2 && lane != 2'd0);
  assign do_op = state == S_WAIT && cnt == 4'd0;
  assign req_ready = reset && state == S_IDLE;
  assign resp_valid = state == S_RESP;
  always_comb begin
    ld = r_size == 2'd0 ? {{24{sh[7] & ~r_uns}}, sh[7:0]} :
         r_size == 2'd1 ? {{16{sh[15] & ~r_uns}}, sh[15:0]} : word;
    be = r_size == 2'd0 ? 4'b0001 << lane : r_size == 2'd1 ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
    wd = r_size == 2'd0 ? {4{r_wdata[7:0]}} : r_size == 2'd1 ? {2{r_wdata[15:0]}} : r_wdata;
    merged = word;
    for (int i = 0; i < 4; i++) merged[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : word[i*8 +: 8];
  end
  always_comb begin
    state_nx = state;
    state_nx = state == S_IDLE ? (req_valid ? S_WAIT : S_IDLE) :
               state == S_WAIT ? (cnt == 4'd0 ? S_RESP : S_WAIT) : S_IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      r_write <= 1'b0;
      r_uns <= 1'b0;
      r_size <= 2'd0;
      r_addr <= '0;
      r_wdata <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && req_valid) begin
        r_write <= req_write;
        r_uns <= req_unsigned;
        r_size <= req_size;
        r_addr <= req_addr[ADDR_W+1:0];
        r_wdata <= req_wdata;
        cnt <= 4'(WAIT_STATES);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_op) begin
        resp_err <= err;
        resp_rdata <= (r_write || err) ? 32'd0 : ld;
      end
    end
  end
  // storage is deliberately left out of reset so contents survive an aborted request
  always_ff @(posedge clk)
    if (do_op && r_write && !err) mem[idx] <= merged;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: vector-driven check of the responder, plus backpressure and reset-abort sequences
module tb_data_mem_responder;
  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic rdy1, rv1, err1, rdy3, rv3, err3;
  logic [31:0] rd1, rd3;
  int sel = 1;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(5), .WAIT_STATES(1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(rdy1), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1));
  data_mem_responder #(.ADDR_W(5), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(rdy3), .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3));

  wire rdy = sel == 3 ? rdy3 : rdy1;
  wire rv = sel == 3 ? rv3 : rv1;
  wire [31:0] rd = sel == 3 ? rd3 : rd1;
  wire er = sel == 3 ? err3 : err1;

  typedef struct {
    string name;
    logic wr;
    logic [1:0] size;
    logic uns;
    logic [31:0] addr, wdata, exp_rdata;
    logic exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_write = v.wr;
    req_size = v.size;
    req_unsigned = v.uns;
    req_addr = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
  endtask

  task automatic txn(input vec_t v, input int ws);
    int n, lat;
    drive(v);
    n = 0;
    while (!rdy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({v.name, " ready"}, {31'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rv && lat < 40) begin
      chk({v.name, " busy"}, {31'd0, rdy}, 32'd0);
      @(posedge clk); #1; lat++;
    end
    chk({v.name, " latency"}, lat, ws + 1);
    chk({v.name, " rdata"}, rd, v.exp_rdata);
    chk({v.name, " err"}, {31'd0, er}, {31'd0, v.exp_err});
    @(posedge clk); #1;
    chk({v.name, " pulse"}, {31'd0, rv}, 32'd0);
    chk({v.name, " idle"}, {31'd0, rdy}, 32'd1);
    chk({v.name, " hold"}, rd, v.exp_rdata);
  endtask

  vec_t tab[16];
  vec_t a, b;
  int resp_cnt;

  initial begin
    tab[0]  = '{"st_word",   1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0};
    tab[1]  = '{"ld_word",   0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0};
    tab[2]  = '{"st_byte",   1, 2'd0, 0, 32'h12, 32'hFFFFFF80, 32'h0,        0};
    tab[3]  = '{"ld_merge",  0, 2'd2, 1, 32'h10, 32'h0,        32'hDE80BEEF, 0};
    tab[4]  = '{"ld_sbyte",  0, 2'd0, 0, 32'h12, 32'h0,        32'hFFFFFF80, 0};
    tab[5]  = '{"ld_ubyte",  0, 2'd0, 1, 32'h12, 32'h0,        32'h00000080, 0};
    tab[6]  = '{"st_half",   1, 2'd1, 0, 32'h16, 32'hFFFF8001, 32'h0,        0};
    tab[7]  = '{"ld_shalf",  0, 2'd1, 0, 32'h16, 32'h0,        32'hFFFF8001, 0};
    tab[8]  = '{"ld_uhalf",  0, 2'd1, 1, 32'h16, 32'h0,        32'h00008001, 0};
    tab[9]  = '{"ld_mishalf",0, 2'd1, 0, 32'h11, 32'h0,        32'h0,        1};
    tab[10] = '{"st_misword",1, 2'd2, 0, 32'h12, 32'h55555555, 32'h0,        1};
    tab[11] = '{"ld_intact", 0, 2'd2, 0, 32'h10, 32'h0,        32'hDE80BEEF, 0};
    tab[12] = '{"ld_size3",  0, 2'd3, 0, 32'h10, 32'h0,        32'h0,        1};
    tab[13] = '{"st_wrap",   1, 2'd2, 0, 32'h90, 32'h12345678, 32'h0,        0};
    tab[14] = '{"ld_wrap",   0, 2'd2, 0, 32'h10, 32'h0,        32'h12345678, 0};
    tab[15] = '{"ld_ubyte1", 0, 2'd0, 1, 32'h11, 32'h0,        32'h00000056, 0};

    #12;
    chk("rst ready", {31'd0, rdy1}, 32'd0);
    chk("rst valid", {31'd0, rv1}, 32'd0);
    chk("rst rdata", rd1, 32'd0);
    chk("rst err", {31'd0, err1}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("idle ready", {31'd0, rdy1}, 32'd1);

    sel = 1;
    for (int i = 0; i < 16; i++) txn(tab[i], 1);

    // a second request held through WAIT/RESP must be taken once, on the first IDLE edge
    a = '{"bp_a", 0, 2'd2, 0, 32'h10, 32'h0, 32'h12345678, 0};
    b = '{"bp_b", 0, 2'd0, 1, 32'h10, 32'h0, 32'h00000078, 0};
    drive(a);
    @(posedge clk); #1;
    drive(b);
    resp_cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      chk("bp busy", {31'd0, rdy1}, 32'd0);
      if (rv1) begin
        resp_cnt++;
        chk("bp a rdata", rd1, a.exp_rdata);
      end
      @(posedge clk); #1;
    end
    chk("bp back idle", {31'd0, rdy1}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp b taken", {31'd0, rdy1}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      if (rv1) begin
        resp_cnt++;
        chk("bp b rdata", rd1, b.exp_rdata);
      end
      @(posedge clk); #1;
    end
    chk("bp responses", resp_cnt, 2);

    // abort a pending store by reset while it sits in WAIT
    sel = 3;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    txn('{"rs_pre", 1, 2'd2, 0, 32'h20, 32'h11111111, 32'h0, 0}, 3);
    drive('{"rs_st", 1, 2'd2, 0, 32'h20, 32'hAAAAAAAA, 32'h0, 0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rs in wait", {31'd0, rdy3}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("rs ready", {31'd0, rdy3}, 32'd0);
    chk("rs valid", {31'd0, rv3}, 32'd0);
    chk("rs rdata", rd3, 32'd0);
    chk("rs err", {31'd0, err3}, 32'd0);
    resp_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rv3) resp_cnt++;
    end
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (rv3) resp_cnt++;
    end
    chk("rs no resp", resp_cnt, 0);
    txn('{"rs_ld", 0, 2'd2, 0, 32'h20, 32'h0, 32'h11111111, 0}, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
